// File: rtl/bus_arbiter_ctrl_if.sv
// Handshake bundle between the masters and the bus arbiter.
// The master modport faces the requesters; slave faces the arbiter.
interface bus_arbiter_ctrl_if #(
  parameter int NO_MASTERS = 2,
  parameter int S_ID_WIDTH = 2,
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
);
  logic [NO_MASTERS-1:0] req;
  logic [NO_MASTERS-1:0] cmd;
  logic [NO_MASTERS-1:0] grant;
  logic [M_ID_WIDTH-1:0] master_sel;
  logic [S_ID_WIDTH-1:0] slave_sel;
  logic                  connected;
  logic                  id_err;

  modport master (
    output req, cmd,
    input  grant, master_sel, slave_sel,
    input  connected, id_err
  );

  modport slave (
    input  req, cmd,
    output grant, master_sel, slave_sel,
    output connected, id_err
  );
endinterface

// File: rtl/bus_arbiter_ctrl.sv
// Bus arbiter: grants one master, shifts in a serial slave ID, holds the path.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module bus_arbiter_ctrl #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES+1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(S_ID_WIDTH+1);

  typedef enum logic [1:0] {
    IDLE, ADDR, CONNECT, RELEASE
  } state_t;

  state_t                state_q, state_d;
  logic [NO_MASTERS-1:0] grant_q, grant_d;
  logic [M_ID_WIDTH-1:0] msel_q, msel_d;
  logic [S_ID_WIDTH-1:0] ssel_q, ssel_d;
  logic                  conn_q, conn_d;
  logic                  err_q, err_d;
  logic [S_ID_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [M_ID_WIDTH-1:0] win;
  logic                  found;
  logic                  cmd_bit;
  logic                  req_bit;
  logic [S_ID_WIDTH-1:0] sr_nxt;
  logic                  id_ok;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [M_ID_WIDTH-1:0] last_q, last_d;

  // Search starts one past the last granted master and wraps.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      idx = (int'(last_q) + 1 + i) % NO_MASTERS;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = M_ID_WIDTH'(idx);
      end
    end
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        win   = M_ID_WIDTH'(i);
      end
    end
  end
`endif

  assign cmd_bit = bus.cmd[msel_q];
  assign req_bit = bus.req[msel_q];
  assign sr_nxt  = S_ID_WIDTH'({sr_q, cmd_bit});
  assign id_ok   = (sr_nxt != '0) &&
                   (int'(sr_nxt) <= NO_SLAVES);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    msel_d  = msel_q;
    ssel_d  = ssel_q;
    conn_d  = conn_q;
    err_d   = 1'b0;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          msel_d       = win;
          sr_d         = '0;
          cnt_d        = '0;
          state_d      = ADDR;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_d       = win;
`endif
        end
      end
      ADDR: begin
        if (!req_bit) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          sr_d  = sr_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(S_ID_WIDTH-1)) begin
            if (id_ok) begin
              ssel_d  = sr_nxt;
              conn_d  = 1'b1;
              state_d = CONNECT;
            end else begin
              err_d   = 1'b1;
              grant_d = '0;
              state_d = IDLE;
            end
          end
        end
      end
      CONNECT: begin
        if (!req_bit) begin
          grant_d = '0;
          conn_d  = 1'b0;
          ssel_d  = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      msel_q  <= '0;
      ssel_q  <= '0;
      conn_q  <= 1'b0;
      err_q   <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_q  <= M_ID_WIDTH'(NO_MASTERS-1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      msel_q  <= msel_d;
      ssel_q  <= ssel_d;
      conn_q  <= conn_d;
      err_q   <= err_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.grant      = grant_q;
  assign bus.master_sel = msel_q;
  assign bus.slave_sel  = ssel_q;
  assign bus.connected  = conn_q;
  assign bus.id_err     = err_q;
endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed bench for bus_arbiter_ctrl at default parameters.
// Expectations for the second contended grant depend on BUS_ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] G_SECOND = 2'b10;
  localparam logic [0:0] M_SECOND = 1'b1;
`else
  localparam logic [1:0] G_SECOND = 2'b01;
  localparam logic [0:0] M_SECOND = 1'b0;
`endif

  bus_arbiter_ctrl_if #(
    .NO_MASTERS(2), .S_ID_WIDTH(2), .M_ID_WIDTH(1)
  ) bus ();

  bus_arbiter_ctrl #(
    .NO_MASTERS(2), .NO_SLAVES(3),
    .S_ID_WIDTH(2), .M_ID_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [1:0] g,
                           input logic       m,
                           input logic [1:0] s,
                           input logic       c,
                           input logic       e);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".msel"}, 32'(bus.master_sel), 32'(m));
    check({tag, ".ssel"}, 32'(bus.slave_sel), 32'(s));
    check({tag, ".conn"}, 32'(bus.connected), 32'(c));
    check({tag, ".err"}, 32'(bus.id_err), 32'(e));
  endtask

  initial begin
    bus.req = 2'b00;
    bus.cmd = 2'b00;
    #3;
    check_all("reset", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Master 0 addresses slave 2
    bus.req = 2'b01;
    tick();
    check_all("t1_grant", 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
    bus.cmd = 2'b01;
    tick();
    check_all("t1_bit1", 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
    bus.cmd = 2'b00;
    tick();
    check_all("t1_conn", 2'b01, 1'b0, 2'd2, 1'b1, 1'b0);
    bus.req = 2'b11;
    tick();
    check_all("t1_nopreempt", 2'b01, 1'b0, 2'd2, 1'b1, 1'b0);

    // Release
    bus.req = 2'b00;
    tick();
    check_all("t1_release", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    check_all("t1_idle", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);

    // Master 1 sends ID 0 -> error
    bus.req = 2'b10;
    tick();
    check_all("t2_grant", 2'b10, 1'b1, 2'd0, 1'b0, 1'b0);
    bus.cmd = 2'b00;
    tick();
    tick();
    check_all("t2_err", 2'b00, 1'b1, 2'd0, 1'b0, 1'b1);
    bus.req = 2'b00;
    tick();
    check_all("t2_errgone", 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);

    // Master 1 sends ID 3
    bus.req = 2'b10;
    tick();
    bus.cmd = 2'b10;
    tick();
    tick();
    check_all("t3_conn", 2'b10, 1'b1, 2'd3, 1'b1, 1'b0);
    bus.req = 2'b00;
    bus.cmd = 2'b00;
    tick();
    check_all("t3_release", 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();

    // Contention: both masters request
    bus.req = 2'b11;
    tick();
    check_all("t4_first", 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
    bus.cmd = 2'b00;
    tick();
    bus.cmd = 2'b01;
    tick();
    check_all("t4_conn", 2'b01, 1'b0, 2'd1, 1'b1, 1'b0);
    bus.cmd = 2'b00;
    bus.req = 2'b10;
    tick();
    check_all("t4_release", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    bus.req = 2'b11;
    tick();
    check("t4_idle.grant", 32'(bus.grant), 32'd0);
    tick();
    check_all("t4_second", G_SECOND, M_SECOND, 2'd0, 1'b0, 1'b0);

    // Abort after one ADDR bit
    tick();
    bus.req = 2'b00;
    tick();
    check_all("t5_abort", 2'b00, M_SECOND, 2'd0, 1'b0, 1'b0);
    tick();
    check("t5_quiet.err", 32'(bus.id_err), 32'd0);

    // Async reset mid-CONNECT
    bus.req = 2'b01;
    tick();
    bus.cmd = 2'b01;
    tick();
    tick();
    check_all("t6_conn", 2'b01, 1'b0, 2'd3, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("t6_async", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    bus.req = 2'b00;
    bus.cmd = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 2'b01;
    tick();
    check_all("t6_fresh", 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
